rf_seq_loader: RTL and testbench

- Initiator-side sequencer for the register file's read/write port.
- Phase 1 (LOAD): accepts a stream of R_NO words over a valid/ready handshake and writes word k into register k through rd/we/indata.
- Phase 2 (VERIFY): accepts the same stream again, reads register k on rs1 and rs2, and compares both read values against the streamed word.
- Used for register-file bring-up and self-check in hardware; reports pass/fail, an error count and the first failing address.

---
 rtl/rf_seq_loader.sv | 120 ++++++++++++
 tb/tb_rf_seq_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rf_seq_loader.sv
// Register-file bring-up sequencer: streams R_NO words into the regfile (LOAD),
// then streams them again and checks both read ports against them (VERIFY).
module rf_seq_loader #(
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int R_NO    = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [REG_W-1:0]  rs1,
  output logic [REG_W-1:0]  rs2,
  output logic [REG_W-1:0]  rd,
  output logic              we,
  output logic [DATA_W-1:0] indata,
  input  logic [DATA_W-1:0] rv1,
  input  logic [DATA_W-1:0] rv2,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [REG_W:0]    err_count,
  output logic [REG_W-1:0]  err_addr
);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, VERIFY, DONE} state_t;

  localparam logic [REG_W:0] K_LAST  = (REG_W+1)'(R_NO - 1);
  localparam logic [REG_W:0] ERR_MAX = (REG_W+1)'(R_NO);
  localparam logic [REG_W:0] ONE     = (REG_W+1)'(1);

  state_t            state, state_nxt;
  logic [REG_W:0]    k;
  logic              accept, last, is_r0, mismatch;
  logic [DATA_W-1:0] expected;
  logic [REG_W:0]    err_nxt;

  function automatic logic [REG_W:0] sat_inc(input logic [REG_W:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + ONE;
  endfunction

  assign last     = (k == K_LAST);
  assign is_r0    = ZERO_R0 && (k == '0);
  assign accept   = in_valid && in_ready;
  assign expected = is_r0 ? '0 : in_data;
  assign mismatch = (state == VERIFY) && accept && ((rv1 != expected) || (rv2 != expected));
  assign err_nxt  = mismatch ? sat_inc(err_count) : err_count;
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    we        = 1'b0;
    busy      = 1'b0;
    rs1       = '0;
    rs2       = '0;
    rd        = '0;
    indata    = '0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        rd       = k[REG_W-1:0];
        indata   = in_data;
        // Register 0 word is still consumed even when its write is suppressed.
        we       = in_valid && !is_r0;
        if (in_valid && last) state_nxt = GAP;
      end
      GAP: begin
        busy      = 1'b1;
        state_nxt = VERIFY;
      end
      VERIFY: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        rs1      = k[REG_W-1:0];
        rs2      = k[REG_W-1:0];
        if (in_valid && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          k         <= '0;
          pass      <= 1'b0;
          err_count <= '0;
          err_addr  <= '0;
        end
        LOAD: if (accept) k <= last ? '0 : k + ONE;
        VERIFY: if (accept) begin
          k <= last ? '0 : k + ONE;
          if (mismatch) begin
            err_count <= err_nxt;
            if (err_count == '0) err_addr <= k[REG_W-1:0];
          end
          // Verdict includes the final compare, so it uses the next error count.
          if (last) pass <= (err_nxt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_seq_loader.sv
// Directed bench for rf_seq_loader: two instances (ZERO_R0=1 and 0) share one
// stream and each drives its own behavioural regfile with a hardwired-zero x0.
module tb_rf_seq_loader;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int R_NO   = 32;

  logic clk = 1'b0;
  logic reset, start, in_valid, fault_en;
  logic [DATA_W-1:0] in_data;

  logic              a_in_ready, a_we, a_busy, a_done, a_pass;
  logic [REG_W-1:0]  a_rs1, a_rs2, a_rd, a_err_addr;
  logic [DATA_W-1:0] a_indata, a_rv1, a_rv2;
  logic [REG_W:0]    a_err_count;

  logic              b_in_ready, b_we, b_busy, b_done, b_pass;
  logic [REG_W-1:0]  b_rs1, b_rs2, b_rd, b_err_addr;
  logic [DATA_W-1:0] b_indata, b_rv1, b_rv2;
  logic [REG_W:0]    b_err_count;

  logic [DATA_W-1:0] rf_a [R_NO];
  logic [DATA_W-1:0] rf_b [R_NO];

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  rf_seq_loader #(.REG_W(REG_W), .DATA_W(DATA_W), .R_NO(R_NO), .ZERO_R0(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .we(a_we),
    .indata(a_indata), .rv1(a_rv1), .rv2(a_rv2), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err_count), .err_addr(a_err_addr));

  rf_seq_loader #(.REG_W(REG_W), .DATA_W(DATA_W), .R_NO(R_NO), .ZERO_R0(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .we(b_we),
    .indata(b_indata), .rv1(b_rv1), .rv2(b_rv2), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err_count), .err_addr(b_err_addr));

  always @(posedge clk) begin
    if (a_we && a_rd != '0) rf_a[a_rd] <= a_indata;
    if (b_we && b_rd != '0) rf_b[b_rd] <= b_indata;
  end

  assign a_rv1 = (a_rs1 == '0) ? '0 : rf_a[a_rs1];
  assign a_rv2 = (fault_en && (a_rs2 == 5'd7 || a_rs2 == 5'd9)) ? 32'hDEAD_BEEF :
                 (a_rs2 == '0) ? '0 : rf_a[a_rs2];
  assign b_rv1 = (b_rs1 == '0) ? '0 : rf_b[b_rs1];
  assign b_rv2 = (fault_en && (b_rs2 == 5'd7 || b_rs2 == 5'd9)) ? 32'hDEAD_BEEF :
                 (b_rs2 == '0) ? '0 : rf_b[b_rs2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] word(input int i, input logic [DATA_W-1:0] w0);
    return (i == 0) ? w0 : 32'hA5A5_0000 + 32'(i);
  endfunction

  function automatic logic [63:0] ctrl_a();
    return 64'({a_in_ready, a_we, a_busy, a_done, a_pass, a_err_count,
                a_err_addr, a_rs1, a_rs2, a_rd});
  endfunction

  // One LOAD+VERIFY run; ls/vs = index at which to stall 3 cycles (-1 = none),
  // abort_k = LOAD index at which reset is raised (-1 = none), ign = stray starts.
  task automatic run(input int ls, input int vs, input int abort_k, input bit ign,
                     input logic [DATA_W-1:0] w0, output int ncyc);
    int idx, phase, stall, we0;
    bit lsd, vsd, ivd, acc;
    idx = 0; phase = 0; stall = 0; we0 = 0; lsd = 0; vsd = 0; ivd = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ncyc = 2; in_valid = 1'b1; in_data = word(0, w0);
    forever begin
      @(negedge clk);
      if (a_done || ncyc > 300) break;
      if (a_we && a_rd == '0) we0++;
      if (!in_valid) begin
        chk("stall_we", 64'(a_we), 64'd0);
        chk("stall_k", 64'((phase == 0) ? a_rd : a_rs1), 64'(idx));
      end
      acc = in_valid && a_in_ready;
      @(posedge clk); #1;
      ncyc++;
      start = 1'b0;
      if (acc) begin
        idx++;
        if (idx == R_NO) begin idx = 0; phase = 1; end
      end
      if (abort_k >= 0 && phase == 0 && idx == abort_k) begin
        chk("abort_rd", 64'(a_rd), 64'(abort_k));
        reset = 1'b1;
        #1;
        chk("abort_ctrl", ctrl_a(), 64'd0);
        chk("abort_indata", 64'(a_indata), 64'd0);
        return;
      end
      if (!lsd && phase == 0 && idx == ls) begin stall = 3; lsd = 1; end
      if (!vsd && phase == 1 && idx == vs) begin stall = 3; vsd = 1; end
      if (ign && !ivd && phase == 1 && idx == 10) begin start = 1'b1; ivd = 1; end
      in_valid = (stall == 0);
      if (stall > 0) stall--;
      in_data = word(idx, w0);
    end
    chk("done_seen", 64'(a_done), 64'd1);
    chk("we_r0", 64'(we0), 64'd0);
    in_valid = 1'b0;
    if (ign) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("ign_busy", 64'(a_busy), 64'd0);
        chk("ign_done", 64'(a_done), 64'd0);
      end
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; fault_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", ctrl_a(), 64'd0);
    chk("rst_indata", 64'(a_indata), 64'd0);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("idle_ctrl", ctrl_a(), 64'd0);
    in_valid = 1'b0;

    // Clean run
    run(-1, -1, -1, 1'b0, 32'hA5A5_0000, cyc);
    chk("clean_cycles", 64'(cyc), 64'd67);
    chk("clean_pass", 64'(a_pass), 64'd1);
    chk("clean_errcnt", 64'(a_err_count), 64'd0);
    chk("clean_erraddr", 64'(a_err_addr), 64'd0);

    // Fault injection on rv2 at 7 and 9, plus stray starts in VERIFY and DONE
    fault_en = 1'b1;
    run(-1, -1, -1, 1'b1, 32'hA5A5_0000, cyc);
    fault_en = 1'b0;
    chk("fault_cycles", 64'(cyc), 64'd67);
    chk("fault_pass", 64'(a_pass), 64'd0);
    chk("fault_errcnt", 64'(a_err_count), 64'd2);
    chk("fault_erraddr", 64'(a_err_addr), 64'd7);

    // Stalls at k=4 in LOAD and k=20 in VERIFY
    run(4, 20, -1, 1'b0, 32'hA5A5_0000, cyc);
    chk("stall_cycles", 64'(cyc), 64'd73);
    chk("stall_pass", 64'(a_pass), 64'd1);
    chk("stall_errcnt", 64'(a_err_count), 64'd0);

    // Register 0 with an all-ones stream word
    run(-1, -1, -1, 1'b0, 32'hFFFF_FFFF, cyc);
    chk("r0_pass_z1", 64'(a_pass), 64'd1);
    chk("r0_errcnt_z1", 64'(a_err_count), 64'd0);
    chk("r0_pass_z0", 64'(b_pass), 64'd0);
    chk("r0_errcnt_z0", 64'(b_err_count), 64'd1);
    chk("r0_erraddr_z0", 64'(b_err_addr), 64'd0);

    // Reset mid-LOAD, then a clean run
    run(-1, -1, 10, 1'b0, 32'hA5A5_0000, cyc);
    repeat (3) begin
      @(negedge clk);
      chk("abort_we", 64'(a_we), 64'd0);
      chk("abort_busy", 64'(a_busy), 64'd0);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    run(-1, -1, -1, 1'b0, 32'hA5A5_0000, cyc);
    chk("rerun_cycles", 64'(cyc), 64'd67);
    chk("rerun_pass", 64'(a_pass), 64'd1);
    chk("rerun_errcnt", 64'(a_err_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
